// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
package lsu_pkg;

  localparam int unsigned MEM_ADDR_W = 21;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CAP_ADDR_W = MEM_ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef struct packed {
    logic                  we;
    size_e                 size;
    logic                  uns;
    logic [CAP_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  // Byte-lane enables of an access at offset 0.
  function automatic logic [3:0] size_mask(input size_e s);
    case (s)
      BYTE:    size_mask = 4'b0001;
      HALF:    size_mask = 4'b0011;
      WORD:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane datapath: write mask/data placement and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  mask_o,
  output logic [63:0] wide_o,
  output logic [31:0] load_o,
  output logic        split_o
);

  logic [31:0] shifted;

  always_comb begin
    mask_o  = {4'b0000, size_mask(size_i)} << off_i;
    wide_o  = {32'h0, wdata_i} << {off_i, 3'b000};
    split_o = |mask_o[7:4];
    shifted = 32'(rdata_i >> {off_i, 3'b000});
    load_o  = '0;
    case (size_i)
      BYTE:    load_o = uns_i ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    load_o = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      WORD:    load_o = shifted;
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master: turns one core request into one or two word accesses on an SRAM-style port.
module lsu_mem_master
  import lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  cs,
  output logic                  wr,
  output logic [3:0]            mask,
  output logic [31:0]           data_wr,
  output logic [MEM_ADDR_W-1:0] addr,
  input  logic [31:0]           data_rd
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] lo_q, lo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [7:0]            al_mask;
  logic [63:0]           al_wide;
  logic [31:0]           al_load;
  logic                  al_split;
  logic [63:0]           rd_pair;
  logic [MEM_ADDR_W-1:0] word_addr;

  // Address bits above the 8 MiB window are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:CAP_ADDR_W];

  assign word_addr = req_q.addr[CAP_ADDR_W-1:2];
  assign rd_pair   = (state_q == ACC2) ? {data_rd, lo_q} : {32'h0, data_rd};

  lsu_align u_align (
    .size_i  (req_q.size),
    .uns_i   (req_q.uns),
    .off_i   (req_q.addr[1:0]),
    .wdata_i (req_q.wdata),
    .rdata_i (rd_pair),
    .mask_o  (al_mask),
    .wide_o  (al_wide),
    .load_o  (al_load),
    .split_o (al_split)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state, response capture and memory port decode from registered state.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    cs          = 1'b1;
    wr          = 1'b1;
    mask        = '0;
    data_wr     = '0;
    addr        = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.size  = size_e'(req_size);
          req_d.uns   = req_unsigned;
          req_d.addr  = req_addr[CAP_ADDR_W-1:0];
          req_d.wdata = req_wdata;
          if (size_e'(req_size) == ILLEGAL) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = ACC1;
            rsp_err_d = 1'b0;
          end
        end
      end

      ACC1: begin
        cs      = 1'b0;
        wr      = ~req_q.we;
        addr    = word_addr;
        mask    = req_q.we ? al_mask[3:0] : 4'b0000;
        data_wr = al_wide[31:0];
        lo_d    = data_rd;
        if (al_split) begin
          state_d = ACC2;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = req_q.we ? 32'h0 : al_load;
        end
      end

      ACC2: begin
        cs          = 1'b0;
        wr          = ~req_q.we;
        addr        = word_addr + MEM_ADDR_W'(1);
        mask        = req_q.we ? al_mask[7:4] : 4'b0000;
        data_wr     = al_wide[63:32];
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = req_q.we ? 32'h0 : al_load;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a negedge-write, async-read word memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] data_wr;
  logic [20:0] addr;
  logic [31:0] data_rd = '0;

  lsu_mem_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .cs           (cs),
    .wr           (wr),
    .mask         (mask),
    .data_wr      (data_wr),
    .addr         (addr),
    .data_rd      (data_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [20:0] a;
    logic [3:0]  m;
    logic        w;
    logic [31:0] d;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic [31:0] mem [logic [20:0]];
  int          mem_gen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory commits writes at the negedge inside an access cycle.
  always @(negedge clk) begin
    if (cs === 1'b0 && wr === 1'b0) begin
      logic [31:0] w;
      w = mem.exists(addr) ? mem[addr] : 32'h0;
      for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data_wr[8*b +: 8];
      mem[addr] = w;
      mem_gen++;
    end
  end

  always @(addr or mem_gen) data_rd = mem.exists(addr) ? mem[addr] : 32'h0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response and memory-access monitor.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_latency_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
      if (cs === 1'b0) begin
        if (acc_q.size() == 0) begin
          check("acc_unexpected", 64'(addr), 64'hFFFF_FFFF);
        end else begin
          acc_t x;
          x = acc_q.pop_front();
          check("acc_addr", 64'(addr), 64'(x.a));
          check("acc_mask", 64'(mask), 64'(x.m));
          check("acc_wr", 64'(wr), 64'(x.w));
          check("acc_data_wr", 64'(data_wr), 64'(x.d));
        end
      end else begin
        check("mem_idle", 64'({cs, wr, mask, data_wr, addr}), 64'({1'b1, 1'b1, 4'h0, 32'h0, 21'h0}));
      end
    end
  end

  task automatic exp_acc(input logic [20:0] a, input logic [3:0] m, input logic w, input logic [31:0] d);
    acc_t x;
    x.a = a; x.m = m; x.w = w; x.d = d;
    acc_q.push_back(x);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input int lat, input bit push);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) check("req_ready_timeout", 64'(req_ready), 64'(1));
    if (push) begin
      rsp_t e;
      e.err = e_err; e.rd = e_rd; e.cyc = cyc + lat;
      rsp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after capture; the DUT must ignore them.
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~un;
    req_addr = ~a; req_wdata = ~wd;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
    check("drain_acc_q", 64'(acc_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Aligned word store / load.
    exp_acc(21'h40, 4'b1111, 1'b0, 32'hA1B2C3D4);
    issue(1, 2'b10, 0, 32'h100, 32'hA1B2C3D4, 0, 32'h0, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hA1B2C3D4, 2, 1);

    // Byte lane 3 stores and sign handling.
    exp_acc(21'h40, 4'b1000, 1'b0, 32'h5A000000);
    issue(1, 2'b00, 0, 32'h103, 32'h5A, 0, 32'h0, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h0000005A, 2, 1);
    exp_acc(21'h40, 4'b1000, 1'b0, 32'h80000000);
    issue(1, 2'b00, 0, 32'h103, 32'h80, 0, 32'h0, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b00, 0, 32'h103, 32'h0, 0, 32'hFFFFFF80, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h00000080, 2, 1);

    // Halfword and byte loads at other offsets of 0x80B2C3D4.
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b01, 0, 32'h102, 32'h0, 0, 32'hFFFF80B2, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b01, 1, 32'h100, 32'h0, 0, 32'h0000C3D4, 2, 1);
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b00, 0, 32'h101, 32'h0, 0, 32'hFFFFFFC3, 2, 1);

    // Misaligned half crossing a word.
    exp_acc(21'h1, 4'b1000, 1'b0, 32'hEF000000);
    exp_acc(21'h2, 4'b0001, 1'b0, 32'h000000BE);
    issue(1, 2'b01, 0, 32'h7, 32'hBEEF, 0, 32'h0, 3, 1);
    exp_acc(21'h1, 4'b0000, 1'b1, 32'h0);
    exp_acc(21'h2, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b01, 1, 32'h7, 32'h0, 0, 32'h0000BEEF, 3, 1);
    exp_acc(21'h1, 4'b0000, 1'b1, 32'h0);
    exp_acc(21'h2, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b01, 0, 32'h7, 32'h0, 0, 32'hFFFFBEEF, 3, 1);

    // Split word wrapping the top of the word address space.
    exp_acc(21'h1FFFFF, 4'b1100, 1'b0, 32'h33440000);
    exp_acc(21'h000000, 4'b0011, 1'b0, 32'h00001122);
    issue(1, 2'b10, 0, 32'h007FFFFE, 32'h11223344, 0, 32'h0, 3, 1);
    exp_acc(21'h1FFFFF, 4'b0000, 1'b1, 32'h0);
    exp_acc(21'h000000, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b10, 0, 32'h007FFFFE, 32'h0, 0, 32'h11223344, 3, 1);

    // Upper address bits are ignored.
    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b10, 0, 32'hFF800100, 32'h0, 0, 32'h80B2C3D4, 2, 1);

    // Illegal size: error response, no memory access, error held until next legal request.
    issue(1, 2'b11, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1, 1);
    drain();
    repeat (2) @(negedge clk);
    check("err_hold", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b0, 1'b1, 32'h0}));
    @(posedge clk); #1;
    exp_acc(21'h1, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b00, 1, 32'h7, 32'h0, 0, 32'h000000EF, 2, 1);
    drain();

    // Reset during ACC2 of a split load: no response, ready right after.
    exp_acc(21'h1, 4'b0000, 1'b1, 32'h0);
    exp_acc(21'h2, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b01, 1, 32'h7, 32'h0, 0, 32'h0, 3, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(req_ready), 64'(1));
    check("midreset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    @(negedge clk);
    check("midreset_ready_after", 64'(req_ready), 64'(1));
    check("midreset_acc_q", 64'(acc_q.size()), 64'(0));
    @(posedge clk); #1;

    exp_acc(21'h40, 4'b0000, 1'b1, 32'h0);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 0, 32'h80B2C3D4, 2, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-low, port rst (asserted when rst==0, sampled on posedge clk).
REQ-002 SHALL declare ports in this order:
- clk  in  1  clock
- rst  in  1  sync active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block accepts request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  zero-extend load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  illegal size, valid with rsp_valid
- rsp_rdata  out  32  extended load data
- cs  out  1  memory select, active-low
- wr  out  1  0=write, 1=read
- mask  out  4  byte-lane write enables
- data_wr  out  32  memory write data
- addr  out  21  memory word address
- data_rd  in  32  memory asynchronous read data

Function
REQ-003 SHALL use states IDLE, ACC1, ACC2, RESP.
REQ-004 SHALL assert req_ready only in IDLE; req_valid&&req_ready captures all req_* fields and enters ACC1, or RESP with rsp_err=1 if req_size==11.
REQ-005 SHALL ignore req_* changes after capture.
REQ-006 SHALL drive cs=1, wr=1, mask=0, data_wr=0 and addr=0 in IDLE and RESP.
REQ-007 SHALL drive memory ports from registered state/captured request only, with no combinational path from req_* to memory ports.
REQ-008 Definitions:
- o = addr[1:0]
- n = 1/2/4 bytes for size 00/01/10
- full = (2^n-1)<<o, 8 bits
- wide = zero-extended wdata << 8*o, 64 bits
REQ-009 In ACC1, SHALL drive:
- cs=0, wr=~we, addr=req_addr[22:2]
- mask=full[3:0] for stores, 0 for loads
- data_wr=wide[31:0]
REQ-010 SHALL go ACC1->ACC2 when full[7:4]!=0 (misaligned, crosses word), else ACC1->RESP.
REQ-011 In ACC2, SHALL drive:
- cs=0, wr=~we
- addr=req_addr[22:2]+1, wrapping 0x1FFFFF->0x000000
- mask=full[7:4] for stores, 0 for loads
- data_wr=wide[63:32]
REQ-012 On loads, SHALL capture data_rd at the posedge ending ACC1 (lo) and ACC2 (hi; hi=0 if no ACC2).
REQ-013 SHALL form loaded value ({hi,lo} >> 8*o), truncated to n bytes, sign-extended unless req_unsigned or size=word.
REQ-014 In RESP, SHALL pulse rsp_valid=1 for exactly one cycle with rsp_rdata (0 for stores/errors) and rsp_err, then return to IDLE.
REQ-015 SHALL hold rsp_rdata and rsp_err until next RESP; rsp_err clears on the next accepted legal request.
REQ-016 Latency accept->rsp_valid: 2 cycles aligned, 3 cycles split, 1 cycle illegal.
REQ-017 SHALL ignore req_addr[31:23].

Reset
REQ-018 On rst==0 at posedge clk, SHALL enter IDLE: rsp_valid=0, rsp_err=0, rsp_rdata=0, captured request cleared; memory ports go to REQ-006 values.
REQ-019 Reset mid-operation SHALL abandon the access with no rsp_valid; a write already committed at the preceding negedge is not undone.

Structure
REQ-020 SHALL place these in shared package lsu_pkg:
- state enum
- size enum (BYTE, HALF, WORD, ILLEGAL)
- MEM_ADDR_W=21
REQ-021 SHALL place mask/shift/extend datapath in combinational sub-module lsu_align.

Verification
REQ-022 Store word 0xA1B2C3D4 @0x100 -> one ACC1: addr=0x40, mask=1111, wr=0, cs=0; rsp_valid 2 cycles after accept.
REQ-023 Store byte 0x5A @0x103 -> mask=1000, data_wr=0x5A000000; load byte signed @0x103 -> rsp_rdata=0x0000005A; after storing 0x80 there, signed -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-024 Store half 0xBEEF @0x7 -> ACC1 addr=1 mask=1000 data_wr[31:24]=0xEF, ACC2 addr=2 mask=0001 data_wr[7:0]=0xBE; load half unsigned @0x7 -> 0x0000BEEF, latency 3.
REQ-025 Store word 0x11223344 @0x7FFFFE -> split: addr 0x1FFFFF (mask 1100), then 0x000000 (mask 0011).
REQ-026 req_size=11 -> no cs assertion; rsp_valid=1, rsp_err=1 next cycle. Reset low during ACC2 of split load -> no rsp_valid; req_ready=1 the cycle after reset releases.
